sm_collector: RTL and testbench

Result-side counterpart of the scoring-bank feeder. It receives per-lane end-of-alignment results (lane 0 = toggle-high target, lane 1 = toggle-low target) from the scoring module. For each result it pops the matching sequence ID from the feeder's per-lane ID FIFO via re0/re1, and pairs ID with score. The pairs are queued in an output FIFO and presented downstream on a valid/ready stream tagged with the lane number.

---
 rtl/sm_collector.sv | 152 +++++++++++++++
 tb/tb_sm_collector.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_collector.sv
// Result collector: pairs per-lane scores with feeder IDs and queues them for a lane-tagged valid/ready stream.
// Optional score filter (discard entries below a threshold) enabled by defining SM_COLLECTOR_SCORE_FILTER_EN.
module sm_collector #(
    parameter int ID_WIDTH    = 48,
    parameter int SCORE_WIDTH = 16,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vld0,
    input  logic [SCORE_WIDTH-1:0] score0,
    input  logic                   vld1,
    input  logic [SCORE_WIDTH-1:0] score1,
    input  logic [ID_WIDTH-1:0]    id0,
    input  logic [ID_WIDTH-1:0]    id1,
`ifdef SM_COLLECTOR_SCORE_FILTER_EN
    input  logic [SCORE_WIDTH-1:0] threshold,
`endif
    output logic                   re0,
    output logic                   re1,
    output logic                   stall,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_WIDTH-1:0]    out_id,
    output logic [SCORE_WIDTH-1:0] out_score,
    output logic                   out_lane,
    output logic                   err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic                   r_p0, r_p1;
    logic [ID_WIDTH-1:0]    r_h0_id, r_h1_id;
    logic [SCORE_WIDTH-1:0] r_h0_score, r_h1_score;
    logic                   r_last;
    logic                   r_same;
    logic                   r_old_lane;
    logic                   r_err;

    logic [ID_WIDTH-1:0]    r_mem_id    [DEPTH];
    logic [SCORE_WIDTH-1:0] r_mem_score [DEPTH];
    logic                   r_mem_lane  [DEPTH];
    logic [AW-1:0]          r_wptr, r_rptr;
    logic [CW-1:0]          r_count;

    logic                   w_any, w_sel, w_pop, w_room, w_drop, w_push, w_serve;
    logic                   w_srv0, w_srv1, w_cap0, w_cap1, w_ovf;
    logic [ID_WIDTH-1:0]    w_sel_id;
    logic [SCORE_WIDTH-1:0] w_sel_score;

    assign re0 = vld0;
    assign re1 = vld1;

    assign w_any  = r_p0 | r_p1;
    assign w_pop  = (r_count != '0) & out_ready;
    assign w_room = (r_count != CW'(DEPTH)) | w_pop;

    // With both lanes pending, the older capture goes first; same-cycle captures alternate.
    always_comb begin
        w_sel = 1'b0;
        if (r_p0 & r_p1)
            w_sel = r_same ? ~r_last : r_old_lane;
        else
            w_sel = r_p1;
    end

    assign w_sel_id    = w_sel ? r_h1_id    : r_h0_id;
    assign w_sel_score = w_sel ? r_h1_score : r_h0_score;

`ifdef SM_COLLECTOR_SCORE_FILTER_EN
    assign w_drop = w_any & (w_sel_score < threshold);
`else
    assign w_drop = 1'b0;
`endif

    assign w_push  = w_any & ~w_drop & w_room;
    assign w_serve = w_push | w_drop;
    assign w_srv0  = w_serve & ~w_sel;
    assign w_srv1  = w_serve & w_sel;

    assign w_cap0 = vld0 & (~r_p0 | w_srv0);
    assign w_cap1 = vld1 & (~r_p1 | w_srv1);
    assign w_ovf  = (vld0 & r_p0 & ~w_srv0) | (vld1 & r_p1 & ~w_srv1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_p0       <= 1'b0;
            r_p1       <= 1'b0;
            r_h0_id    <= '0;
            r_h1_id    <= '0;
            r_h0_score <= '0;
            r_h1_score <= '0;
            r_last     <= 1'b1;
            r_same     <= 1'b0;
            r_old_lane <= 1'b0;
            r_err      <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_p0 <= w_cap0 | (r_p0 & ~w_srv0);
            r_p1 <= w_cap1 | (r_p1 & ~w_srv1);
            if (w_cap0) begin
                r_h0_id    <= id0;
                r_h0_score <= score0;
            end
            if (w_cap1) begin
                r_h1_id    <= id1;
                r_h1_score <= score1;
            end
            if (w_serve)
                r_last <= w_sel;
            if (w_cap0 & w_cap1) begin
                r_same <= 1'b1;
            end else if (w_cap0) begin
                r_same     <= 1'b0;
                r_old_lane <= 1'b1;
            end else if (w_cap1) begin
                r_same     <= 1'b0;
                r_old_lane <= 1'b0;
            end
            if (w_ovf)
                r_err <= 1'b1;
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_id[r_wptr]    <= w_sel_id;
            r_mem_score[r_wptr] <= w_sel_score;
            r_mem_lane[r_wptr]  <= w_sel;
        end
    end

    assign stall     = r_p0 | r_p1 | (r_count >= CW'(DEPTH - 1));
    assign out_valid = (r_count != '0);
    assign out_id    = out_valid ? r_mem_id[r_rptr]    : '0;
    assign out_score = out_valid ? r_mem_score[r_rptr] : '0;
    assign out_lane  = out_valid ? r_mem_lane[r_rptr]  : 1'b0;
    assign err       = r_err;

endmodule

// File: tb/tb_sm_collector.sv
// Self-checking bench for sm_collector: directed scenarios plus a randomized stream checked against an ordered scoreboard.
module tb_sm_collector;

    typedef struct {
        logic [47:0] id;
        logic [15:0] score;
        logic        lane;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vld0 = 1'b0, vld1 = 1'b0;
    logic [15:0] score0 = '0, score1 = '0;
    logic [47:0] id0 = '0, id1 = '0;
    logic        re0, re1, stall, out_valid, out_lane, err;
    logic        out_ready = 1'b0;
    logic [47:0] out_id;
    logic [15:0] out_score;
`ifdef SM_COLLECTOR_SCORE_FILTER_EN
    logic [15:0] threshold = '0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    res_t q[$];
    logic model_last = 1'b1;

    sm_collector #(.ID_WIDTH(48), .SCORE_WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .vld0(vld0), .score0(score0), .vld1(vld1), .score1(score1),
        .id0(id0), .id1(id1),
`ifdef SM_COLLECTOR_SCORE_FILTER_EN
        .threshold(threshold),
`endif
        .re0(re0), .re1(re1), .stall(stall),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_score(out_score), .out_lane(out_lane),
        .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input logic lane, input logic [47:0] id, input logic [15:0] sc);
        res_t r;
        r.id = id; r.score = sc; r.lane = lane;
        q.push_back(r);
        model_last = lane;
    endtask

    // One-cycle result pulse on a lane; keep=1 records it as an expected output.
    task automatic send(input logic lane, input logic [47:0] id, input logic [15:0] sc, input logic keep);
        if (lane) begin vld1 = 1'b1; id1 = id; score1 = sc; end
        else      begin vld0 = 1'b1; id0 = id; score0 = sc; end
        #1;
        chk("re_lane", lane ? re1 : re0, 1);
        chk("re_other", lane ? re0 : re1, 0);
        if (keep) expect_push(lane, id, sc);
        step();
        vld0 = 1'b0;
        vld1 = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int t = 0; t < 80 && q.size() != 0; t++) begin
            if (out_valid) begin
                chk({tag, "_id"},    out_id,    q[0].id);
                chk({tag, "_score"}, out_score, q[0].score);
                chk({tag, "_lane"},  out_lane,  q[0].lane);
                void'(q.pop_front());
            end
            step();
        end
        chk({tag, "_left"}, q.size(), 0);
        chk({tag, "_empty"}, out_valid, 0);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        q.delete();
        model_last = 1'b1;
    endtask

    initial begin
        logic        v0, v1;
        logic [47:0] ri0, ri1;
        logic [15:0] rs0, rs1;

        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        chk("rst_valid", out_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_err", err, 0);
        chk("rst_re0", re0, 0);
        chk("rst_re1", re1, 0);
        chk("rst_id", out_id, 0);
        chk("rst_score", out_score, 0);
        chk("rst_lane", out_lane, 0);

        // Single result and its two-cycle latency
        send(1'b0, 48'hA1, 16'h0042, 1'b0);
        chk("t1_valid_n1", out_valid, 0);
        chk("t1_stall_n1", stall, 1);
        step();
        chk("t1_valid_n2", out_valid, 1);
        chk("t1_id", out_id, 48'hA1);
        chk("t1_score", out_score, 16'h0042);
        chk("t1_lane", out_lane, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_popped", out_valid, 0);
        chk("t1_stall_end", stall, 0);

        // Simultaneous results after reset: lane 0 first
        do_reset();
        vld0 = 1'b1; id0 = 48'h10; score0 = 16'd5;
        vld1 = 1'b1; id1 = 48'h20; score1 = 16'd9;
        #1;
        chk("t2_re0", re0, 1);
        chk("t2_re1", re1, 1);
        step();
        vld0 = 1'b0; vld1 = 1'b0;
        chk("t2_stall_n1", stall, 1);
        chk("t2_valid_n1", out_valid, 0);
        step();
        chk("t2_valid_n2", out_valid, 1);
        chk("t2_first_lane", out_lane, 0);
        chk("t2_stall_n2", stall, 1);
        step();
        chk("t2_stall_n3", stall, 0);
        expect_push(1'b0, 48'h10, 16'd5);
        expect_push(1'b1, 48'h20, 16'd9);
        drain("t2");

        // Backpressure: four queued, fifth held pending
        for (int k = 0; k < 3; k++) begin
            send(k[0], 48'h300 + 48'(k), 16'd100 + 16'(k), 1'b1);
            step();
            if (k == 1) chk("t3_stall_cnt2", stall, 0);
        end
        chk("t3_stall_cnt3", stall, 1);
        send(1'b1, 48'h303, 16'd103, 1'b1);
        step();
        send(1'b0, 48'h304, 16'd104, 1'b1);
        step();
        step();
        chk("t3_stall_full", stall, 1);
        chk("t3_valid_full", out_valid, 1);
        chk("t3_head_id", out_id, 48'h300);
        drain("t3");
        chk("t3_err", err, 0);

        // Overflow while lane 0 is pending and the FIFO is full
        for (int k = 0; k < 4; k++) begin
            send(k[0], 48'h400 + 48'(k), 16'd200 + 16'(k), 1'b1);
            step();
        end
        send(1'b0, 48'h404, 16'd204, 1'b1);
        step();
        chk("t4_err_before", err, 0);
        send(1'b0, 48'h4FF, 16'd999, 1'b0);
        chk("t4_err_set", err, 1);
        drain("t4");
        step();
        step();
        chk("t4_no_extra", out_valid, 0);
        chk("t4_err_sticky", err, 1);

        // Reset mid-operation
        for (int k = 0; k < 3; k++) begin
            send(k[0], 48'h500 + 48'(k), 16'd50, 1'b0);
            step();
        end
        chk("t5_queued", out_valid, 1);
        do_reset();
        chk("t5_valid", out_valid, 0);
        chk("t5_err", err, 0);
        chk("t5_stall", stall, 0);
        send(1'b1, 48'h5AA, 16'h1234, 1'b1);
        step();
        chk("t5_latency", out_valid, 1);
        drain("t5");

`ifdef SM_COLLECTOR_SCORE_FILTER_EN
        threshold = 16'd10;
        send(1'b1, 48'h609, 16'd9, 1'b0);
        step();
        send(1'b1, 48'h60A, 16'd10, 1'b1);
        step();
        send(1'b1, 48'h60B, 16'd11, 1'b1);
        step();
        drain("t6");
        threshold = 16'd0;
`endif

        // Randomized stream, obeying stall, random backpressure
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            v0 = 1'b0;
            v1 = 1'b0;
            if (!stall) begin
                v0 = ($urandom_range(0, 2) == 0);
                v1 = ($urandom_range(0, 2) == 0);
            end
            ri0 = {16'($urandom), $urandom()};
            ri1 = {16'($urandom), $urandom()};
            rs0 = 16'($urandom);
            rs1 = 16'($urandom);
            vld0 = v0; id0 = ri0; score0 = rs0;
            vld1 = v1; id1 = ri1; score1 = rs1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (v0 && v1) begin
                if (model_last) begin
                    expect_push(1'b0, ri0, rs0);
                    expect_push(1'b1, ri1, rs1);
                end else begin
                    expect_push(1'b1, ri1, rs1);
                    expect_push(1'b0, ri0, rs0);
                end
            end else if (v0) begin
                expect_push(1'b0, ri0, rs0);
            end else if (v1) begin
                expect_push(1'b1, ri1, rs1);
            end
            #1;
            chk("rnd_re0", re0, v0);
            chk("rnd_re1", re1, v1);
            chk("rnd_spurious", out_valid & (q.size() == 0), 0);
            if (out_valid && out_ready && q.size() != 0) begin
                chk("rnd_id", out_id, q[0].id);
                chk("rnd_score", out_score, q[0].score);
                chk("rnd_lane", out_lane, q[0].lane);
                void'(q.pop_front());
            end
            step();
        end
        vld0 = 1'b0;
        vld1 = 1'b0;
        drain("rnd_drain");
        chk("rnd_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
